// File: rtl/confusedcore_pkg.sv
// Shared types and constants for the core's off-chip I/O bridge.
package confusedcore_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int ROM_WORDS      = 256;
    localparam int FLASH_CNT_W    = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_HOLD,
        ST_FLASH,
        ST_FLASH_HOLD,
        ST_FLASH_DONE
    } bridge_state_t;

    // An 8-bit length of zero encodes a full ROM image.
    function automatic logic [FLASH_CNT_W-1:0] flash_words(input logic [7:0] len);
        return (len == 8'd0) ? FLASH_CNT_W'(ROM_WORDS) : {1'b0, len};
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible whenever not empty.
module io_fifo
    import confusedcore_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic              w_wr;
    logic              w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/io_host_bridge.sv
// Host-side partner of the core's parallel port: serves input words from a
// host FIFO, sequences ROM flashing, and captures core output words.
module io_host_bridge
    import confusedcore_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] hostInData,
    input  logic              hostInValid,
    output logic              hostInReady,
    input  logic              flashReq,
    input  logic [7:0]        flashLen,
    output logic              flashBusy,
    input  logic              inputWaiting,
    output logic              inputReady,
    output logic [DATA_W-1:0] parallelIn,
    output logic              flashEnable,
    input  logic [DATA_W-1:0] parallelOut,
    input  logic              outStrobe,
    output logic [DATA_W-1:0] hostOutData,
    output logic              hostOutValid,
    input  logic              hostOutReady,
    output logic              outOverflow
);

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_serve;
    logic [DATA_W-1:0]      w_head;

    bridge_state_t          r_state;
    logic [FLASH_CNT_W-1:0] r_remaining;
    logic                   r_inputReady;
    logic [DATA_W-1:0]      r_parallelIn;
    logic                   r_flashEnable;
    logic                   r_flashBusy;
    logic [DATA_W-1:0]      r_hostOutData;
    logic                   r_hostOutValid;
    logic                   r_outOverflow;

    // Held low during reset so every output reads zero while reset is applied.
    assign hostInReady = reset && !w_full;
    assign w_push      = hostInValid && hostInReady;
    assign w_serve     = inputWaiting && !w_empty;

    // The word is popped on the edge that registers it into parallelIn.
    assign w_pop = w_serve && (((r_state == ST_IDLE) && !flashReq) || (r_state == ST_FLASH));

    io_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (hostInData),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_inputReady  <= 1'b0;
            r_parallelIn  <= '0;
            r_flashEnable <= 1'b0;
            r_flashBusy   <= 1'b0;
        end else begin
            r_inputReady <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (flashReq) begin
                        r_remaining   <= flash_words(flashLen);
                        r_flashEnable <= 1'b1;
                        r_flashBusy   <= 1'b1;
                        r_state       <= ST_FLASH;
                    end else if (w_serve) begin
                        r_parallelIn <= w_head;
                        r_inputReady <= 1'b1;
                        r_state      <= ST_SERVE;
                    end
                end
                ST_SERVE: r_state <= ST_HOLD;
                // One word per request: wait for the core to drop its request.
                ST_HOLD: if (!inputWaiting) r_state <= ST_IDLE;
                ST_FLASH: begin
                    if (w_serve) begin
                        r_parallelIn <= w_head;
                        r_inputReady <= 1'b1;
                        if (r_remaining != '0) r_remaining <= r_remaining - 1'b1;
                        r_state <= ST_FLASH_HOLD;
                    end
                end
                ST_FLASH_HOLD: begin
                    if (!inputWaiting)
                        r_state <= (r_remaining == '0) ? ST_FLASH_DONE : ST_FLASH;
                end
                ST_FLASH_DONE: begin
                    r_flashEnable <= 1'b0;
                    r_flashBusy   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Single output holding register; a strobe that cannot land is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hostOutData  <= '0;
            r_hostOutValid <= 1'b0;
            r_outOverflow  <= 1'b0;
        end else if (outStrobe) begin
            if (!r_hostOutValid || hostOutReady) begin
                r_hostOutData  <= parallelOut;
                r_hostOutValid <= 1'b1;
            end else begin
                r_outOverflow <= 1'b1;
            end
        end else if (r_hostOutValid && hostOutReady) begin
            r_hostOutValid <= 1'b0;
        end
    end

    assign inputReady   = r_inputReady;
    assign parallelIn   = r_parallelIn;
    assign flashEnable  = r_flashEnable;
    assign flashBusy    = r_flashBusy;
    assign hostOutData  = r_hostOutData;
    assign hostOutValid = r_hostOutValid;
    assign outOverflow  = r_outOverflow;

endmodule

// File: tb/tb_io_host_bridge.sv
// Self-checking bench for io_host_bridge: output-path vector table, directed
// handshake/flash sequences, and a randomized input stream against a scoreboard.
module tb_io_host_bridge;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] hostInData = '0;
    logic          hostInValid = 1'b0;
    logic          hostInReady;
    logic          flashReq = 1'b0;
    logic [7:0]    flashLen = '0;
    logic          flashBusy;
    logic          inputWaiting = 1'b0;
    logic          inputReady;
    logic [DW-1:0] parallelIn;
    logic          flashEnable;
    logic [DW-1:0] parallelOut = '0;
    logic          outStrobe = 1'b0;
    logic [DW-1:0] hostOutData;
    logic          hostOutValid;
    logic          hostOutReady = 1'b0;
    logic          outOverflow;

    io_host_bridge #(.DATA_W(DW), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .hostInData   (hostInData),
        .hostInValid  (hostInValid),
        .hostInReady  (hostInReady),
        .flashReq     (flashReq),
        .flashLen     (flashLen),
        .flashBusy    (flashBusy),
        .inputWaiting (inputWaiting),
        .inputReady   (inputReady),
        .parallelIn   (parallelIn),
        .flashEnable  (flashEnable),
        .parallelOut  (parallelOut),
        .outStrobe    (outStrobe),
        .hostOutData  (hostOutData),
        .hostOutValid (hostOutValid),
        .hostOutReady (hostOutReady),
        .outOverflow  (outOverflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          strobe;
        logic [DW-1:0] pout;
        logic          rdy;
        logic          exp_v;
        logic [DW-1:0] exp_d;
        logic          exp_o;
    } ovec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        hostInValid = 1'b0; flashReq = 1'b0; inputWaiting = 1'b0;
        outStrobe = 1'b0; hostOutReady = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic push(input logic [DW-1:0] w);
        hostInData  = w;
        hostInValid = 1'b1;
        tick();
        hostInValid = 1'b0;
    endtask

    // Raise inputWaiting and wait (bounded) for the pulse; leaves the request high.
    task automatic get_word(output logic ok, output logic [DW-1:0] d, output int lat);
        inputWaiting = 1'b1;
        ok = 1'b0; d = '0; lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (inputReady) begin
                ok = 1'b1; d = parallelIn; lat = k;
                break;
            end
        end
    endtask

    task automatic release_req();
        inputWaiting = 1'b0;
        tick(); tick();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_hostInReady"}, hostInReady, 0);
        chk({nm, "_inputReady"}, inputReady, 0);
        chk({nm, "_parallelIn"}, parallelIn, 0);
        chk({nm, "_flashEnable"}, flashEnable, 0);
        chk({nm, "_flashBusy"}, flashBusy, 0);
        chk({nm, "_hostOutValid"}, hostOutValid, 0);
        chk({nm, "_hostOutData"}, hostOutData, 0);
        chk({nm, "_outOverflow"}, outOverflow, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ovec_t         ovt[8];
        logic          ok;
        logic [DW-1:0] d;
        int            lat, npul, first, bad;
        logic [DW-1:0] q[$];
        logic          got;
        int            hold, low, wait_cnt, rnd_pulses;

        ovt[0] = '{1'b1, 16'h0042, 1'b0, 1'b1, 16'h0042, 1'b0};
        ovt[1] = '{1'b1, 16'h0043, 1'b0, 1'b1, 16'h0042, 1'b1};
        ovt[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0042, 1'b1};
        ovt[3] = '{1'b1, 16'h0044, 1'b1, 1'b1, 16'h0044, 1'b1};
        ovt[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0044, 1'b1};
        ovt[5] = '{1'b1, 16'h0045, 1'b1, 1'b1, 16'h0045, 1'b1};
        ovt[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0045, 1'b1};
        ovt[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0045, 1'b1};

        // Reset state
        reset = 1'b0;
        tick(); tick();
        check_reset_outputs("rst");
        reset = 1'b1;
        tick();
        chk("rst_release_hostInReady", hostInReady, 1);

        // Output path table
        for (int i = 0; i < 8; i++) begin
            outStrobe = ovt[i].strobe; parallelOut = ovt[i].pout; hostOutReady = ovt[i].rdy;
            tick();
            chk($sformatf("out%0d_valid", i), hostOutValid, ovt[i].exp_v);
            chk($sformatf("out%0d_data", i), hostOutData, ovt[i].exp_d);
            chk($sformatf("out%0d_ovf", i), outOverflow, ovt[i].exp_o);
        end
        outStrobe = 1'b0; hostOutReady = 1'b0;

        // One word per request, even with inputWaiting held
        reset_dut();
        push(16'h1234); push(16'hBEEF);
        inputWaiting = 1'b1; npul = 0; first = 0; d = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (inputReady) begin
                npul++;
                if (first == 0) first = k;
                d = parallelIn;
            end
        end
        chk("t1_pulses", npul, 1);
        chk("t1_latency", first, 1);
        chk("t1_data", d, 16'h1234);
        chk("t1_hold", parallelIn, 16'h1234);
        inputWaiting = 1'b0;
        tick();
        get_word(ok, d, lat);
        chk("t1_second_ok", ok, 1);
        chk("t1_second_data", d, 16'hBEEF);
        release_req();

        // Empty FIFO stalls, then serves without bypass
        inputWaiting = 1'b1; npul = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (inputReady) npul++;
        end
        chk("t2_empty_pulses", npul, 0);
        push(16'h00AA);
        get_word(ok, d, lat);
        chk("t2_ok", ok, 1);
        chk("t2_data", d, 16'h00AA);
        chk("t2_latency", lat, 1);
        release_req();

        // Three-word flash
        push(16'h1001); push(16'h1002); push(16'h1003);
        flashLen = 8'd3; flashReq = 1'b1;
        tick();
        flashReq = 1'b0;
        chk("t3_enable_entry", flashEnable, 1);
        chk("t3_busy_entry", flashBusy, 1);
        for (int i = 0; i < 3; i++) begin
            get_word(ok, d, lat);
            chk($sformatf("t3_word%0d_ok", i), ok, 1);
            chk($sformatf("t3_word%0d_data", i), d, 16'h1001 + i);
            chk($sformatf("t3_word%0d_enable", i), flashEnable, 1);
            inputWaiting = 1'b0;
            tick();
        end
        chk("t3_enable_done", flashEnable, 1);
        chk("t3_busy_done", flashBusy, 1);
        tick();
        chk("t3_enable_fall", flashEnable, 0);
        chk("t3_busy_fall", flashBusy, 0);

        // Full 256-word image; flashReq mid-flash ignored
        flashLen = 8'd0; flashReq = 1'b1;
        tick();
        flashReq = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!flashEnable) bad++;
            if (i == 100) begin flashReq = 1'b1; flashLen = 8'd5; end
            push(DW'(i * 3 + 7));
            get_word(ok, d, lat);
            flashReq = 1'b0;
            if (!ok || d !== DW'(i * 3 + 7)) bad++;
            inputWaiting = 1'b0;
            tick();
        end
        chk("t4_image_errors", bad, 0);
        chk("t4_enable_after_256", flashEnable, 1);
        tick();
        chk("t4_enable_fall", flashEnable, 0);
        chk("t4_busy_fall", flashBusy, 0);

        // Reset in the middle of a flash
        flashLen = 8'd5; flashReq = 1'b1;
        tick();
        flashReq = 1'b0;
        push(16'h6000); push(16'h6001);
        for (int i = 0; i < 2; i++) begin
            get_word(ok, d, lat);
            inputWaiting = 1'b0;
            tick();
        end
        push(16'h6002); push(16'h6003);
        outStrobe = 1'b1; parallelOut = 16'h7777;
        tick();
        outStrobe = 1'b0;
        chk("t6_pre_enable", flashEnable, 1);
        chk("t6_pre_outvalid", hostOutValid, 1);
        reset = 1'b0;
        tick();
        check_reset_outputs("t6_rst");
        reset = 1'b1;
        tick();
        chk("t6_hostInReady", hostInReady, 1);
        inputWaiting = 1'b1; npul = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (inputReady) npul++;
        end
        chk("t6_fifo_flushed", npul, 0);
        push(16'h5555);
        get_word(ok, d, lat);
        chk("t6_serve_data", d, 16'h5555);
        chk("t6_idle_not_flash", flashEnable, 0);
        release_req();

        // Randomized host stream against a FIFO-order scoreboard
        reset_dut();
        q.delete();
        got = 1'b0; hold = 0; low = 0; wait_cnt = 0; rnd_pulses = 0;
        inputWaiting = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            hostInValid = (c < 2600) && ($urandom_range(1, 0) == 0);
            hostInData  = DW'($urandom);
            if (hostInValid && hostInReady) q.push_back(hostInData);
            tick();
            if (inputReady) begin
                if (!inputWaiting || got) begin
                    chk("rnd_extra_pulse", 1, 0);
                end else if (q.size() == 0) begin
                    chk("rnd_underflow", 1, 0);
                end else begin
                    chk("rnd_data", parallelIn, q.pop_front());
                    got = 1'b1; hold = $urandom_range(3, 0); rnd_pulses++;
                end
            end
            if (inputWaiting) begin
                if (got) begin
                    if (hold == 0) begin
                        inputWaiting = 1'b0; got = 1'b0; low = 2 + $urandom_range(2, 0);
                    end else hold--;
                end else begin
                    wait_cnt++;
                    if (wait_cnt > 8 && q.size() > 0) begin
                        chk("rnd_stall", 1, 0);
                        wait_cnt = 0;
                    end
                end
            end else if (low > 0) begin
                low--;
            end else if ($urandom_range(2, 0) == 0) begin
                inputWaiting = 1'b1; wait_cnt = 0;
            end
        end
        hostInValid = 1'b0;
        chk("rnd_drained", q.size(), 0);
        chk("rnd_activity", rnd_pulses > 100, 1);
        inputWaiting = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_host_bridge.md
Name: io_host_bridge

Overview:
Off-chip-side partner of the core's parallel I/O port. It answers the core's input requests (inputWaiting/inputReady/parallelIn) from a buffered host word stream, and captures core output words (parallelOut) into a host output stream. It also sequences ROM flashing: it drives flashEnable and feeds a fixed-length program image through the same input handshake.

Parameters:
DATA_W, 16, word width of all data paths; must match the core's parallel port.
FIFO_DEPTH, 4, host-input FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-low reset
hostInData  input  DATA_W  host word to deliver to the core
hostInValid  input  1  hostInData valid
hostInReady  output  1  FIFO can accept; equals !full
flashReq  input  1  start a flash sequence; sampled only in IDLE
flashLen  input  8  program length in words; 0 means 256
flashBusy  output  1  high from FLASH entry through FLASH_DONE
inputWaiting  input  1  core requests one input word (level)
inputReady  output  1  one-cycle pulse: parallelIn is valid
parallelIn  output  DATA_W  word delivered to the core
flashEnable  output  1  core loads ROM from the input port while high
parallelOut  input  DATA_W  core output word
outStrobe  input  1  core wrote parallelOut this cycle
hostOutData  output  DATA_W  captured output word
hostOutValid  output  1  hostOutData valid
hostOutReady  input  1  host accepts hostOutData
outOverflow  output  1  sticky: an outStrobe arrived while the output register was full

Behaviour:
- Reset (reset==0 at posedge): all outputs 0, FIFO flushed, state IDLE, flash counter 0, outOverflow cleared.
- FIFO: a push occurs on hostInValid && hostInReady. There is no bypass, so a word written in cycle N can be popped no earlier than N+1. Push and pop in the same cycle are legal, including when full (hostInReady is still low when full, so no push then).
- States: IDLE, SERVE, HOLD, FLASH, FLASH_HOLD, FLASH_DONE.
- IDLE:
  - flashReq=1 has priority: latch remaining = (flashLen==0 ? 256 : flashLen) in a 9-bit counter, go to FLASH, and set flashEnable=1 at that edge.
  - Otherwise, inputWaiting && !empty: go to SERVE.
- SERVE: register parallelIn = FIFO head, pop, pulse inputReady=1 for exactly this cycle, go to HOLD. Latency from inputWaiting rising (FIFO non-empty, IDLE) to the inputReady pulse is 1 cycle.
- HOLD: parallelIn holds its value. Stay until inputWaiting==0, then return to IDLE. This guarantees one word per request even if the core holds inputWaiting high for several cycles.
- FLASH: if inputWaiting && !empty, deliver a word exactly as in SERVE (pop, pulse inputReady, decrement remaining), then go to FLASH_HOLD.
- FLASH_HOLD: wait for inputWaiting==0. Then, if remaining==0, go to FLASH_DONE; otherwise return to FLASH.
- FLASH_DONE: flashEnable=0, return to IDLE. flashBusy falls on the same edge.
- flashReq is ignored outside IDLE. An empty FIFO in SERVE-eligible or FLASH states stalls indefinitely with inputReady=0 and no timeout.
- The output path is independent of the FSM:
  - outStrobe && !hostOutValid: capture parallelOut and set hostOutValid next cycle.
  - hostOutValid && hostOutReady: clear hostOutValid.
  - outStrobe in the same cycle as a handshake clear: capture the new word and keep hostOutValid=1.
  - outStrobe while hostOutValid && !hostOutReady: drop the word and set outOverflow. outOverflow clears only on reset.
- Reset mid-flash: flashEnable drops at that edge and any partial image is abandoned.
- Widths: remaining is 9 bits and must not wrap; decrement only when nonzero.

Decomposition:
- confusedcore_pkg holds the bridge_state_t enum (6 states above), the DATA_W default, and the flash length constant ROM_WORDS=256.
- One sub-module, io_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH, push/pop/full/empty, and the same clock/reset convention.
- The FSM and output register stay in io_host_bridge.

Test Plan:
1. Push 0x1234 and 0xBEEF; hold inputWaiting high for 5 cycles -> exactly one inputReady pulse with parallelIn=0x1234. Drop then re-raise inputWaiting -> second pulse with 0xBEEF.
2. inputWaiting high, FIFO empty for 10 cycles, then push 0x00AA -> no pulse during the empty period; inputReady pulses with 0x00AA no earlier than 2 cycles after the push.
3. flashReq with flashLen=3; words 0x1001, 0x1002, 0x1003 served over 3 handshakes -> flashEnable high throughout, pulses in order, flashEnable and flashBusy low one cycle after the third inputWaiting drop.
4. flashLen=0 -> exactly 256 words consumed before flashEnable falls. flashReq pulsed mid-flash -> ignored.
5. outStrobe with 0x0042, hostOutReady low, then outStrobe with 0x0043 -> hostOutData stays 0x0042 and outOverflow=1. Then strobe simultaneous with accept -> new word captured, hostOutValid stays 1.
6. reset=0 asserted after 2 of 5 flash words -> flashEnable=0, FIFO empty, outputs 0, state IDLE on the next cycle.
